// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_stream_rr streaming multiplexer.
package mux_pkg;

  typedef enum logic {
    MUX_MODE_FIXED = 1'b0,
    MUX_MODE_RR    = 1'b1
  } mux_mode_e;

  localparam int MUX_MAX_W     = 64;
  localparam int MUX_MAX_BUS_W = 1024;

  // Extract channel ch (w bits wide) from a packed channel bus; caller truncates to its width.
  function automatic logic [MUX_MAX_W-1:0] ch_slice(input logic [MUX_MAX_BUS_W-1:0] bus,
                                                    input int ch, input int w);
    return MUX_MAX_W'(bus >> (ch * w));
  endfunction

endpackage

// File: rtl/mux_stream_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after last_gnt, wrapping at NUM_CH.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last_gnt,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  int   w_best_d;
  int   w_d;
  logic w_take;

  // Pick the requester with the smallest rotated distance from the pointer.
  always_comb begin
    w_best_d  = NUM_CH;
    w_d       = 0;
    w_take    = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_d      = k - int'(last_gnt) - 1;
      w_d      = (w_d < 0) ? w_d + NUM_CH : w_d;
      w_take   = req[k] && (w_d < w_best_d);
      w_best_d = w_take ? w_d : w_best_d;
      gnt_idx  = w_take ? SEL_W'(k) : gnt_idx;
    end
    gnt_valid = |req;
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin arbitration
// and a single registered output stage.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_out_valid;
  logic [SEL_W-1:0]  r_last_gnt;

  logic              w_slot_free;
  logic              w_rr_valid;
  logic [SEL_W-1:0]  w_rr_idx;
  logic              w_fix_valid;
  logic              w_gnt_valid;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic              w_is_rr;
  logic              w_push;
  logic [DATA_W-1:0] w_sel_data;

  assign w_is_rr     = (mux_mode_e'(mode) == MUX_MODE_RR);
  assign w_slot_free = !r_out_valid || out_ready;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req      (in_valid),
    .last_gnt (r_last_gnt),
    .gnt_valid(w_rr_valid),
    .gnt_idx  (w_rr_idx)
  );

  // Fixed-mode grant: out-of-range selects simply match no channel.
  always_comb begin
    w_fix_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_fix_valid = w_fix_valid || (in_valid[k] && (sel == SEL_W'(k)));
    end
  end

  // Grant selection and per-channel ready; ready is held low throughout reset.
  always_comb begin
    in_ready = '0;
    if (w_is_rr) begin
      w_gnt_valid = w_rr_valid;
      w_gnt_idx   = w_rr_idx;
    end else begin
      w_gnt_valid = w_fix_valid;
      w_gnt_idx   = sel;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = rst_n && w_slot_free && w_gnt_valid && (w_gnt_idx == SEL_W'(k));
    end
  end

  assign w_push     = |(in_valid & in_ready);
  assign w_sel_data = DATA_W'(ch_slice(MUX_MAX_BUS_W'(in_data), int'(w_gnt_idx), DATA_W));

  // Output register and round-robin pointer; only RR transfers move the pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_last_gnt  <= SEL_W'(NUM_CH - 1);
    end else if (w_push) begin
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_gnt_idx;
      r_out_valid <= 1'b1;
      if (w_is_rr) begin
        r_last_gnt <= w_gnt_idx;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Directed self-checking bench for mux_stream_rr (4-channel instance plus a 3-channel instance).
module tb_mux_stream_rr;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;

  int          n_vec;
  int          n_err;
  logic [7:0]  exp_d [4];

  mux_stream_rr #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_stream_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", out_data); end
    n_vec++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d expected 0", out_ch); end
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    @(negedge clk);
    in_valid = 4'b0000;
    rst_n    = 1'b1;
  endtask

  task automatic test_fixed();
    @(negedge clk);
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fixed_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL fixed_data: got %h expected a5", out_data); end
    n_vec++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL fixed_ch: got %0d expected 2", out_ch); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      sel       = 2'd1;
      #1;
      n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready); end
      @(posedge clk); #1;
      n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected a5", i, out_data); end
      n_vec++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL bp_ch[%0d]: got %0d expected 2", i, out_ch); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_valid: got %b expected 1", out_valid); end
    n_vec++; if (out_data !== 8'h5B) begin n_err++; $display("FAIL bp_release_data: got %h expected 5b", out_data); end
    n_vec++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL bp_release_ch: got %0d expected 1", out_ch); end
    // Fixed-mode transfers must have left the pointer at its reset value.
    @(negedge clk);
    mode = 1'b1;
    #1;
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL fixed_ptr_ready: got %b expected 0001", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL fixed_ptr_ch: got %0d expected 0", out_ch); end
  endtask

  task automatic test_rr_all();
    logic [3:0] exp_r;
    int         exp_c;
    @(negedge clk);
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_c = i % 4;
      exp_r = 4'b0001 << exp_c;
      #1;
      n_vec++; if (in_ready !== exp_r) begin n_err++; $display("FAIL rr_all_ready[%0d]: got %b expected %b", i, in_ready, exp_r); end
      @(posedge clk); #1;
      n_vec++; if (out_ch !== 2'(exp_c)) begin n_err++; $display("FAIL rr_all_ch[%0d]: got %0d expected %0d", i, out_ch, exp_c); end
      n_vec++; if (out_data !== exp_d[exp_c]) begin n_err++; $display("FAIL rr_all_data[%0d]: got %h expected %h", i, out_data, exp_d[exp_c]); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_all_valid[%0d]: got %b expected 1", i, out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_sparse();
    logic [3:0] exp_r;
    int         exp_c;
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0) ? 1 : 3;
      exp_r = 4'b0001 << exp_c;
      #1;
      n_vec++; if (in_ready !== exp_r) begin n_err++; $display("FAIL rr_sparse_ready[%0d]: got %b expected %b", i, in_ready, exp_r); end
      @(posedge clk); #1;
      n_vec++; if (out_ch !== 2'(exp_c)) begin n_err++; $display("FAIL rr_sparse_ch[%0d]: got %0d expected %0d", i, out_ch, exp_c); end
      n_vec++; if (out_data !== exp_d[exp_c]) begin n_err++; $display("FAIL rr_sparse_data[%0d]: got %h expected %h", i, out_data, exp_d[exp_c]); end
      @(negedge clk);
    end
  endtask

  task automatic test_out_of_range();
    in_valid = 4'b0000;
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    n_vec++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL oor_ready: got %b expected 000", in_ready3); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL oor_valid[%0d]: got %b expected 0", i, out_valid3); end
    end
    @(negedge clk);
    sel3 = 2'd2;
    #1;
    n_vec++; if (in_ready3 !== 3'b100) begin n_err++; $display("FAIL top_sel_ready: got %b expected 100", in_ready3); end
    @(posedge clk); #1;
    n_vec++; if (out_valid3 !== 1'b1) begin n_err++; $display("FAIL top_sel_valid: got %b expected 1", out_valid3); end
    n_vec++; if (out_ch3 !== 2'd2) begin n_err++; $display("FAIL top_sel_ch: got %0d expected 2", out_ch3); end
    n_vec++; if (out_data3 !== 8'h33) begin n_err++; $display("FAIL top_sel_data: got %h expected 33", out_data3); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid: got %b expected 1", out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h expected 00", out_data); end
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_ready: got %b expected 0000", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_hold_valid: got %b expected 0", out_valid); end
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_hold_ready: got %b expected 0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_rel_ready: got %b expected 0001", in_ready); end
    @(posedge clk); #1;
    n_vec++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL rmid_first_ch: got %0d expected 0", out_ch); end
    n_vec++; if (out_data !== 8'h1C) begin n_err++; $display("FAIL rmid_first_data: got %h expected 1c", out_data); end
    @(posedge clk); #1;
    n_vec++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL rmid_second_ch: got %0d expected 1", out_ch); end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_d     = '{8'h1C, 8'h5B, 8'hA5, 8'hD3};
    rst_n     = 1'b0;
    in_data   = {8'hD3, 8'hA5, 8'h5B, 8'h1C};
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data3  = {8'h33, 8'h22, 8'h11};
    in_valid3 = 3'b000;
    mode3     = 1'b0;
    sel3      = 2'd0;
    out_ready3 = 1'b1;

    test_reset();
    test_fixed();
    test_backpressure();
    test_rr_all();
    test_rr_sparse();
    test_out_of_range();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output. The channel is picked either by an external select (fixed mode) or by a built-in round-robin arbiter. The output is registered: one pipeline stage, full throughput. It sits between several producer streams and a single consumer, replacing the combinational 4:1 bit mux wherever a handshake and fair sharing are needed.

Parameters:
NUM_CH, 4, number of input channels (>=2).
DATA_W, 8, data width per channel (>=1).
SEL_W, $clog2(NUM_CH), width of select and channel-ID fields (derived; do not override).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  NUM_CH*DATA_W  packed channel data, channel k = in_data[k*DATA_W +: DATA_W].
in_valid  input  NUM_CH  per-channel valid.
in_ready  output  NUM_CH  per-channel ready (combinational).
mode  input  1  0 = fixed select, 1 = round-robin.
sel  input  SEL_W  channel select, used only when mode=0.
out_data  output  DATA_W  registered selected data.
out_ch  output  SEL_W  channel index of the word held in out_data.
out_valid  output  1  output word valid.
out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr pointer last_gnt=NUM_CH-1 (channel 0 has first priority). in_ready=0 while rst_n low.
- slot_free = !out_valid || out_ready.
- Grant, mode=0: grant = sel when sel < NUM_CH and in_valid[sel]=1; otherwise no grant. sel >= NUM_CH is legal and produces no grant.
- Grant, mode=1: search channels last_gnt+1, last_gnt+2, ... modulo NUM_CH. Grant the first channel with in_valid=1. No grant if none are valid.
- in_ready[k] = slot_free && grant valid && grant==k. Exactly one bit or none is set. in_ready may depend on in_valid.
- Transfer on input k when in_valid[k] && in_ready[k]. At that edge: out_data <= channel k data, out_ch <= k, out_valid <= 1.
- If out_valid && out_ready and no input transfer occurs, out_valid <= 0.
- Latency: input word appears on out_data 1 cycle after its transfer. Throughput: 1 word per cycle with out_ready held high.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_ch hold stable and all in_ready=0.
- last_gnt updates to k only on a transfer while mode=1. Fixed-mode transfers do not move the pointer.
- mode and sel are sampled every cycle. Changing them mid-stream affects only the next grant; it never alters a word already held in the output register.
- Pointer wrap: after channel NUM_CH-1 the search continues at channel 0.
- Simultaneous output pop and input push in the same cycle: the new word replaces the old one, and out_valid stays 1.
- Reset asserted mid-transfer: the held word is discarded and out_valid drops immediately (asynchronously). No in_ready is asserted until rst_n is released.

Decomposition:
- Package mux_pkg: typedef enum logic {MUX_MODE_FIXED=1'b0, MUX_MODE_RR=1'b1} mux_mode_e. Also a helper function for the channel-slice extraction.
- Sub-module rr_arbiter, parametrised by NUM_CH. It is purely combinational: inputs req[NUM_CH] and last_gnt; outputs gnt_valid and gnt_idx. The top level owns the pointer register, the output register and the fixed-mode path.

Test Plan:
1. Fixed-mode select: mode=0, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1. Required: in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
2. Backpressure: out_valid=1, out_ready=0 for 3 cycles with all inputs valid. Required: out_data and out_ch stable and in_ready=0 throughout. On the cycle out_ready=1, one new transfer occurs and out_valid stays 1.
3. Round-robin, all channels active: mode=1, all in_valid=1, out_ready=1 for 6 cycles after reset. Required: out_ch sequence 0,1,2,3,0,1.
4. Round-robin, sparse requests: mode=1, in_valid=4'b1010 held. Required: out_ch sequence 1,3,1,3; channels 0 and 2 never get in_ready.
5. Out-of-range select: NUM_CH=3, mode=0, sel=3, in_valid=3'b111. Required: in_ready=0 and out_valid remains 0.
6. Reset mid-stream: pull rst_n low between clock edges while out_valid=1. Required: out_valid=0 and out_data=0 immediately. After release in mode=1 with all valid, the first out_ch is 0.
